// File: rtl/axi4_lite_line_fill.sv
// Line-fill sequencer: fetches WORDS_PER_LINE consecutive words of one aligned
// line through a single-word AXI4-Lite read master and assembles them in o_line.
module axi4_lite_line_fill #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int WORDS_PER_LINE = 16
) (
  input  logic                                     clk,
  input  logic                                     arstn,
  input  logic                                     i_fill_req,
  input  logic [AXI_ADDR_WIDTH-1:0]                i_fill_addr,
  output logic                                     o_busy,
  output logic [AXI_DATA_WIDTH*WORDS_PER_LINE-1:0] o_line,
  output logic                                     o_fill_done,
  output logic                                     o_fill_fault,
  output logic                                     o_start_read,
  output logic [AXI_ADDR_WIDTH-1:0]                o_rd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]                i_rd_data,
  input  logic                                     i_rd_done,
  input  logic                                     i_rd_fault,
  output logic [1:0]                               o_dbg_state
);

  localparam int BYTES_PER_WORD = AXI_DATA_WIDTH / 8;
  localparam int OFF_W          = $clog2(WORDS_PER_LINE * BYTES_PER_WORD);
  localparam int CNT_W          = $clog2(WORDS_PER_LINE);
  localparam logic [AXI_ADDR_WIDTH-1:0] OFF_MASK  = AXI_ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_STEP = AXI_ADDR_WIDTH'(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0]          LAST_WORD = CNT_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                                   r_state;
  state_t                                   w_next;
  logic                                     w_latch;
  logic                                     w_word_wr;
  logic                                     w_advance;
  logic                                     w_set_fault;
  logic [AXI_ADDR_WIDTH-1:0]                w_base;
  logic [AXI_ADDR_WIDTH-1:0]                r_rd_addr;
  logic [CNT_W-1:0]                         r_cnt;
  logic                                     r_fault;
  logic [AXI_DATA_WIDTH*WORDS_PER_LINE-1:0] r_line;

  assign w_base = i_fill_addr & ~OFF_MASK;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Read-master handshake: o_start_read is a one-cycle pulse with o_rd_addr
  // valid; the master answers with a one-cycle i_rd_done carrying data/fault.
  always_comb begin
    w_next      = r_state;
    w_latch     = 1'b0;
    w_word_wr   = 1'b0;
    w_advance   = 1'b0;
    w_set_fault = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_fill_req) begin
          w_latch = 1'b1;
          w_next  = S_REQ;
        end
      end
      S_REQ: w_next = S_WAIT;
      S_WAIT: begin
        if (i_rd_done) begin
          if (i_rd_fault) begin
            w_set_fault = 1'b1;
            w_next      = S_DONE;
          end else begin
            w_word_wr = 1'b1;
            if (r_cnt == LAST_WORD) begin
              w_next = S_DONE;
            end else begin
              w_advance = 1'b1;
              w_next    = S_REQ;
            end
          end
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The read address register doubles as the line base plus word offset; the
  // line is aligned, so stepping by one word never carries past the line.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_rd_addr <= '0;
      r_cnt     <= '0;
      r_fault   <= 1'b0;
      r_line    <= '0;
    end else begin
      if (w_latch) begin
        r_rd_addr <= w_base;
        r_cnt     <= '0;
        r_fault   <= 1'b0;
      end
      if (w_advance) begin
        r_rd_addr <= r_rd_addr + ADDR_STEP;
        r_cnt     <= r_cnt + 1'b1;
      end
      if (w_set_fault) r_fault <= 1'b1;
      for (int k = 0; k < WORDS_PER_LINE; k++) begin
        if (w_word_wr && (r_cnt == CNT_W'(k)))
          r_line[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= i_rd_data;
      end
    end
  end

  assign o_start_read = (r_state == S_REQ);
  assign o_busy       = (r_state != S_IDLE);
  assign o_fill_done  = (r_state == S_DONE);
  assign o_fill_fault = (r_state == S_DONE) && r_fault;
  assign o_rd_addr    = r_rd_addr;
  assign o_line       = r_line;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_axi4_lite_line_fill.sv
// Bench for axi4_lite_line_fill: directed vector table, hand sequences for
// reset/ignored-request corners, and randomized fills against a line model.
module tb_axi4_lite_line_fill;

  localparam int AW         = 64;
  localparam int DW         = 32;
  localparam int WPL        = 16;
  localparam int LW         = DW * WPL;
  localparam int BYTES      = DW / 8;
  localparam int LINE_BYTES = WPL * BYTES;

  logic          clk;
  logic          arstn;
  logic          i_fill_req;
  logic [AW-1:0] i_fill_addr;
  logic          o_busy;
  logic [LW-1:0] o_line;
  logic          o_fill_done;
  logic          o_fill_fault;
  logic          o_start_read;
  logic [AW-1:0] o_rd_addr;
  logic [DW-1:0] i_rd_data;
  logic          i_rd_done;
  logic          i_rd_fault;
  logic [1:0]    o_dbg_state;

  axi4_lite_line_fill #(
    .AXI_ADDR_WIDTH(AW),
    .AXI_DATA_WIDTH(DW),
    .WORDS_PER_LINE(WPL)
  ) dut (
    .clk          (clk),
    .arstn        (arstn),
    .i_fill_req   (i_fill_req),
    .i_fill_addr  (i_fill_addr),
    .o_busy       (o_busy),
    .o_line       (o_line),
    .o_fill_done  (o_fill_done),
    .o_fill_fault (o_fill_fault),
    .o_start_read (o_start_read),
    .o_rd_addr    (o_rd_addr),
    .i_rd_data    (i_rd_data),
    .i_rd_done    (i_rd_done),
    .i_rd_fault   (i_rd_fault),
    .o_dbg_state  (o_dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int            checks   = 0;
  int            failures = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] obs_addr_q[$];
  logic [DW-1:0] exp_words[WPL];
  int            done_cnt = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] model_line();
    logic [LW-1:0] l;
    for (int k = 0; k < WPL; k++) l[k*DW +: DW] = exp_words[k];
    return l;
  endfunction

  always @(negedge clk) if (o_fill_done === 1'b1) done_cnt++;

  // ---------------- read-master responder ----------------
  int            resp_delay = 0;
  int            resp_fault = -1;
  logic [DW-1:0] resp_seed  = '0;
  logic [DW-1:0] resp_mult  = 32'd1;
  bit            spur_req   = 1'b0;

  initial begin
    bit            pending;
    int            cd;
    int            k;
    logic [AW-1:0] pend_addr;
    pending    = 1'b0;
    cd         = 0;
    pend_addr  = '0;
    i_rd_done  = 1'b0;
    i_rd_data  = '0;
    i_rd_fault = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      i_rd_done  = 1'b0;
      i_rd_fault = 1'b0;
      if (!arstn) begin
        pending = 1'b0;
      end else if (spur_req) begin
        i_rd_done  = 1'b1;
        i_rd_fault = 1'b1;
        i_rd_data  = '1;
        spur_req   = 1'b0;
      end else if (pending) begin
        if (cd == 0) begin
          k          = int'((pend_addr % 64'(LINE_BYTES)) / 64'(BYTES));
          i_rd_done  = 1'b1;
          i_rd_data  = resp_seed + DW'(k) * resp_mult;
          i_rd_fault = (k == resp_fault);
          pending    = 1'b0;
        end else begin
          cd--;
        end
      end
      if (arstn && o_start_read) begin
        obs_addr_q.push_back(o_rd_addr);
        pend_addr = o_rd_addr;
        pending   = 1'b1;
        cd        = resp_delay;
      end
    end
  end

  // ---------------- driver: one complete fill ----------------
  // Latency counts cycles inclusively, from the request cycle to the done cycle.
  task automatic do_fill(input logic [AW-1:0] addr, input int fw, input int d,
                         input logic [DW-1:0] seed, input logic [DW-1:0] mult,
                         input logic [AW-1:0] exp_base, input int exp_reads,
                         input logic exp_fault, input int exp_lat, input bit noise);
    int  lat;
    int  n_ok;
    int  done_before;
    int  reads_before;
    bit  seen;
    bit  noise_sent;
    resp_delay = d;
    resp_fault = fw;
    resp_seed  = seed;
    resp_mult  = mult;
    obs_addr_q.delete();
    exp_q.delete();
    for (int k = 0; k < exp_reads; k++) exp_q.push_back(exp_base + AW'(k * BYTES));
    n_ok = (fw >= 0) ? fw : WPL;
    for (int k = 0; k < n_ok; k++) exp_words[k] = seed + DW'(k) * mult;
    done_before = done_cnt;
    noise_sent  = 1'b0;
    seen        = 1'b0;
    @(posedge clk);
    #1;
    i_fill_addr = addr;
    i_fill_req  = 1'b1;
    lat         = 1;
    while (!seen && lat < 2000) begin
      @(posedge clk);
      #1;
      i_fill_req = 1'b0;
      lat++;
      if (o_fill_done) begin
        seen = 1'b1;
      end else if (noise && !noise_sent && o_busy && !o_start_read) begin
        i_fill_addr = 64'hDEAD_0000;
        i_fill_req  = 1'b1;
        noise_sent  = 1'b1;
      end
    end
    if (!seen) begin
      check("fill_timeout", LW'(lat), LW'(exp_lat));
      return;
    end
    check("latency", LW'(lat), LW'(exp_lat));
    check("fill_fault", LW'(o_fill_fault), LW'(exp_fault));
    check("line", o_line, model_line());
    check("read_count", LW'(obs_addr_q.size()), LW'(exp_reads));
    for (int k = 0; k < exp_reads && k < obs_addr_q.size(); k++)
      check($sformatf("rd_addr[%0d]", k), LW'(obs_addr_q[k]), LW'(exp_q[k]));
    if (noise) i_fill_req = 1'b1;
    @(posedge clk);
    #1;
    i_fill_req = 1'b0;
    check("busy_after_done", LW'(o_busy), LW'(0));
    check("done_one_cycle", LW'(o_fill_done), LW'(0));
    if (noise) begin
      reads_before = obs_addr_q.size();
      repeat (6) @(posedge clk);
      #1;
      check("no_queued_fill_reads", LW'(obs_addr_q.size()), LW'(reads_before));
      check("no_queued_fill_busy", LW'(o_busy), LW'(0));
    end
    @(negedge clk);
    check("single_done", LW'(done_cnt), LW'(done_before + 1));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [AW-1:0] addr;
    int            fault_word;
    int            delay;
    logic [DW-1:0] seed;
    logic [DW-1:0] mult;
    logic [AW-1:0] exp_base;
    int            exp_reads;
    logic          exp_fault;
    int            exp_lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{64'h1234,                -1, 0, 32'hA000_0000, 32'd1,  64'h1200,                16, 1'b0, 34};
    vecs[1] = '{64'h5678,                 5, 1, 32'h1111_0000, 32'h10, 64'h5640,                 6, 1'b1, 20};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFF8, -1, 2, 32'hC0DE_0000, 32'd3,  64'hFFFF_FFFF_FFFF_FFC0, 16, 1'b0, 66};
    vecs[3] = '{64'h8000_003F,            0, 0, 32'h5555_0000, 32'd1,  64'h8000_0000,            1, 1'b1, 4};
    vecs[4] = '{64'h40,                  15, 3, 32'h7777_0000, 32'd5,  64'h40,                  16, 1'b1, 82};

    i_fill_req  = 1'b0;
    i_fill_addr = '0;
    arstn       = 1'b1;
    for (int k = 0; k < WPL; k++) exp_words[k] = '0;

    // Reset state, checked before any clock edge.
    #2 arstn = 1'b0;
    #1;
    check("rst_busy", LW'(o_busy), LW'(0));
    check("rst_start_read", LW'(o_start_read), LW'(0));
    check("rst_fill_done", LW'(o_fill_done), LW'(0));
    check("rst_fill_fault", LW'(o_fill_fault), LW'(0));
    check("rst_rd_addr", LW'(o_rd_addr), LW'(0));
    check("rst_line", o_line, LW'(0));
    repeat (2) @(negedge clk);
    arstn = 1'b1;

    for (int i = 0; i < 5; i++)
      do_fill(vecs[i].addr, vecs[i].fault_word, vecs[i].delay, vecs[i].seed, vecs[i].mult,
              vecs[i].exp_base, vecs[i].exp_reads, vecs[i].exp_fault, vecs[i].exp_lat, i == 2);

    // Read completion while idle must not disturb anything.
    obs_addr_q.delete();
    spur_req = 1'b1;
    repeat (3) @(negedge clk);
    check("spur_busy", LW'(o_busy), LW'(0));
    check("spur_line", o_line, model_line());
    check("spur_reads", LW'(obs_addr_q.size()), LW'(0));

    // Reset while waiting for word 7.
    begin
      int done_before;
      resp_delay = 3;
      resp_fault = -1;
      resp_seed  = 32'h3333_0000;
      resp_mult  = 32'd1;
      obs_addr_q.delete();
      @(posedge clk);
      #1;
      i_fill_addr = 64'h2000_0010;
      i_fill_req  = 1'b1;
      @(posedge clk);
      #1;
      i_fill_req = 1'b0;
      for (int c = 0; c < 500 && obs_addr_q.size() < 8; c++) @(negedge clk);
      check("mid_reads_before_rst", LW'(obs_addr_q.size()), LW'(8));
      done_before = done_cnt;
      #2 arstn = 1'b0;
      #1;
      for (int k = 0; k < WPL; k++) exp_words[k] = '0;
      check("mid_rst_busy", LW'(o_busy), LW'(0));
      check("mid_rst_start_read", LW'(o_start_read), LW'(0));
      check("mid_rst_rd_addr", LW'(o_rd_addr), LW'(0));
      check("mid_rst_line", o_line, LW'(0));
      check("mid_rst_fill_done", LW'(o_fill_done), LW'(0));
      repeat (3) @(negedge clk);
      arstn = 1'b1;
      repeat (2) @(negedge clk);
      check("mid_rst_no_done", LW'(done_cnt), LW'(done_before));
      do_fill(64'h2000_0010, -1, 0, 32'h4444_0000, 32'd1, 64'h2000_0000, 16, 1'b0, 34, 1'b0);
    end

    // Randomized fills against the line model.
    for (int r = 0; r < 20; r++) begin
      logic [AW-1:0] a;
      logic [AW-1:0] b;
      int            fw;
      int            d;
      int            nr;
      a  = {$urandom(), $urandom()};
      fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WPL - 1)) : -1;
      d  = int'($urandom_range(0, 3));
      b  = a - (a % 64'(LINE_BYTES));
      nr = (fw >= 0) ? fw + 1 : WPL;
      do_fill(a, fw, d, $urandom(), $urandom() | 32'd1, b, nr, fw >= 0, nr * (d + 2) + 2, r == 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
